// File: rtl/pcm_fifo_arbiter.sv
// pcm_fifo_arbiter
//   Shares one byte-wide TX FIFO between NUM_CH PCM sample sources. Each channel
//   has a one-entry holding register. Pending channels are granted round-robin.
//   A granted sample goes into the FIFO as one tag byte (8'hA0 | channel) and then
//   SAMPLE_W/8 data bytes, least-significant byte first.
//
// Ports
//   clk             system clock
//   rst_n           synchronous, active-low reset
//   enable_i        1 = accept new samples; 0 = finish pending work, capture nothing
//   ch_valid_i      per-channel one-cycle strobe for a new sample
//   ch_data_i       channel i sample at [i*SAMPLE_W +: SAMPLE_W]
//   fifo_full_i     FIFO full flag; stalls serialization in place
//   fifo_wr_en_o    FIFO write strobe, one byte per high cycle
//   fifo_wr_data_o  byte to write, valid while fifo_wr_en_o = 1
//   busy_o          high while a sample is being serialized
//   drop_count_o    saturating count of samples lost to holding-register overrun
module pcm_fifo_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 16,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable_i,
    input  logic [NUM_CH-1:0]          ch_valid_i,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_data_i,
    input  logic                       fifo_full_i,
    output logic                       fifo_wr_en_o,
    output logic [7:0]                 fifo_wr_data_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           drop_count_o
);

    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BYTES  = SAMPLE_W / 8;
    localparam int BCNT_W = 2;
    localparam int SUM_W  = ((CNT_W > 4) ? CNT_W : 4) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [SAMPLE_W-1:0]   shift_q, shift_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [NUM_CH-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [SAMPLE_W-1:0]   hold_q [NUM_CH];

    logic                  req_found;
    logic [IDX_W-1:0]      req_idx;
    logic                  grant_now;
    logic                  wr_en;
    logic [NUM_CH-1:0]     cap_en;
    logic [3:0]            drop_inc;

    // (base + off) mod NUM_CH, for off < NUM_CH
    function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return IDX_W'(s);
    endfunction

    // Saturating accumulate: sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [3:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        if (sum > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
        return sum[CNT_W-1:0];
    endfunction

    // Round-robin search: first pending channel at or above the rr pointer
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!req_found && pending_q[wrap_idx(int'(rr_q), k)]) begin
                req_found = 1'b1;
                req_idx   = wrap_idx(int'(rr_q), k);
            end
        end
    end

    // Serializer FSM next state and FIFO outputs
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        shift_d        = shift_q;
        bcnt_d         = bcnt_q;
        grant_now      = 1'b0;
        wr_en          = (state_q != IDLE) && !fifo_full_i;
        fifo_wr_data_o = 8'h00;

        case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_now = 1'b1;
                    grant_d   = req_idx;
                    shift_d   = hold_q[req_idx];
                    rr_d      = wrap_idx(int'(req_idx), 1);
                    bcnt_d    = '0;
                    state_d   = TAG;
                end
            end
            TAG: begin
                fifo_wr_data_o = 8'hA0 | 8'(grant_q);
                if (wr_en) state_d = DATA;
            end
            DATA: begin
                fifo_wr_data_o = shift_q[7:0];
                if (wr_en) begin
                    shift_d = shift_q >> 8;
                    if (bcnt_q == BCNT_W'(BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture: a channel whose pending sample is granted this cycle may take a
    // new sample in the same cycle; any other overrun is dropped and counted.
    always_comb begin
        pending_d = pending_q;
        cap_en    = '0;
        drop_inc  = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_now && (req_idx == IDX_W'(i))) pending_d[i] = 1'b0;
            if (enable_i && ch_valid_i[i]) begin
                if (!pending_q[i] || (grant_now && (req_idx == IDX_W'(i)))) begin
                    cap_en[i]    = 1'b1;
                    pending_d[i] = 1'b1;
                end else begin
                    drop_inc = drop_inc + 4'd1;
                end
            end
        end
        drop_d = sat_add(drop_q, drop_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            shift_q   <= '0;
            bcnt_q    <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            shift_q   <= shift_d;
            bcnt_q    <= bcnt_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Holding registers carry data only; pending_q qualifies them
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap_en[i]) hold_q[i] <= ch_data_i[i*SAMPLE_W +: SAMPLE_W];
        end
    end

    assign fifo_wr_en_o = wr_en;
    assign busy_o       = (state_q != IDLE);
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_pcm_fifo_arbiter.sv
module tb_pcm_fifo_arbiter;

    localparam int NCH = 3;
    localparam int SW  = 16;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [NCH-1:0]  ch_valid;
    logic [NCH*SW-1:0] ch_data;
    logic            fifo_full;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            busy;
    logic [CW-1:0]   drop_count;

    int tests = 0;
    int fails = 0;

    // Reference model: pending samples per channel plus the byte queue of the
    // sample currently being sent (empty queue = arbiter idle).
    logic [7:0]  m_q[$];
    bit          m_pend[NCH];
    logic [15:0] m_hold[NCH];
    int          m_rr;
    int          m_drop;
    logic [7:0]  got[$];

    pcm_fifo_arbiter #(.NUM_CH(NCH), .SAMPLE_W(SW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .ch_valid_i     (ch_valid),
        .ch_data_i      (ch_data),
        .fifo_full_i    (fifo_full),
        .fifo_wr_en_o   (wr_en),
        .fifo_wr_data_o (wr_data),
        .busy_o         (busy),
        .drop_count_o   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NCH; i++) m_pend[i] = 1'b0;
        m_rr   = 0;
        m_drop = 0;
    endtask

    task automatic model_update();
        int g;
        bit pold[NCH];
        if (!rst_n) begin
            model_reset();
            return;
        end
        pold = m_pend;
        g = -1;
        if (m_q.size() == 0) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (g < 0 && m_pend[c]) g = c;
            end
            if (g >= 0) begin
                m_q.push_back(8'hA0 | 8'(g));
                m_q.push_back(m_hold[g][7:0]);
                m_q.push_back(m_hold[g][15:8]);
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % NCH;
            end
        end else if (!fifo_full) begin
            void'(m_q.pop_front());
        end
        for (int i = 0; i < NCH; i++) begin
            if (enable && ch_valid[i]) begin
                if (!pold[i] || g == i) begin
                    m_hold[i] = ch_data[i*SW +: SW];
                    m_pend[i] = 1'b1;
                end else if (m_drop < SAT) begin
                    m_drop++;
                end
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance model, return just after the edge
    task automatic step();
        @(negedge clk);
        chk("busy", busy, m_q.size() != 0);
        chk("wr_en", wr_en, (m_q.size() != 0) && !fifo_full);
        if (m_q.size() != 0 && !fifo_full) chk("wr_data", wr_data, m_q[0]);
        chk("drop_count", drop_count, m_drop);
        if (wr_en) got.push_back(wr_data);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ch_valid = '0;
        fifo_full = 1'b0;
        enable = 1'b1;
        step();
        rst_n = 1'b1;
        got.delete();
    endtask

    task automatic strobe(input logic [NCH-1:0] mask, input logic [15:0] d0,
                          input logic [15:0] d1, input logic [15:0] d2);
        ch_valid = mask;
        ch_data  = {d2, d1, d0};
        step();
        ch_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        do_reset();

        // single sample, latency and byte order
        strobe(3'b001, 16'h1234, 16'h0, 16'h0);
        step();
        chk("t1_latency", got.size(), 0);
        repeat (3) step();
        chk("t1_count", got.size(), 3);
        chk("t1_tag", got[0], 8'hA0);
        chk("t1_lo", got[1], 8'h34);
        chk("t1_hi", got[2], 8'h12);
        step();
        chk("t1_idle", busy, 0);

        // two channels at once, round-robin order
        do_reset();
        strobe(3'b011, 16'h1111, 16'h2222, 16'h0);
        repeat (8) step();
        strobe(3'b011, 16'h3333, 16'h4444, 16'h0);
        repeat (8) step();
        chk("t2_count", got.size(), 12);
        chk("t2_tag0", got[0], 8'hA0);
        chk("t2_d0", got[1], 8'h11);
        chk("t2_tag1", got[3], 8'hA1);
        chk("t2_d1", got[5], 8'h22);
        chk("t2_next_first", got[6], 8'hA0);
        chk("t2_next_second", got[9], 8'hA1);

        // FIFO full stall mid-data
        do_reset();
        strobe(3'b001, 16'h1234, 16'h0, 16'h0);
        repeat (3) step();
        fifo_full = 1'b1;
        repeat (5) step();
        chk("t3_stalled", got.size(), 2);
        fifo_full = 1'b0;
        step();
        chk("t3_count", got.size(), 3);
        chk("t3_last", got[2], 8'h12);
        repeat (2) step();
        chk("t3_no_repeat", got.size(), 3);

        // overrun while FIFO full
        do_reset();
        fifo_full = 1'b1;
        strobe(3'b010, 16'h0, 16'h0A01, 16'h0);
        step();
        strobe(3'b010, 16'h0, 16'h0B02, 16'h0);
        step();
        strobe(3'b010, 16'h0, 16'h0C03, 16'h0);
        step();
        chk("t4_drop", drop_count, 1);
        fifo_full = 1'b0;
        repeat (10) step();
        chk("t4_count", got.size(), 6);
        chk("t4_first", got[1], 8'h01);
        chk("t4_second", got[4], 8'h02);
        chk("t4_drop_end", drop_count, 1);

        // enable low mid-sample
        do_reset();
        strobe(3'b001, 16'h5678, 16'h0, 16'h0);
        repeat (2) step();
        enable = 1'b0;
        strobe(3'b001, 16'h9999, 16'h0, 16'h0);
        repeat (4) step();
        chk("t5_count", got.size(), 3);
        chk("t5_hi", got[2], 8'h56);
        chk("t5_drop", drop_count, 0);
        enable = 1'b1;

        // reset right after the tag byte
        do_reset();
        strobe(3'b100, 16'h0, 16'h0, 16'hABCD);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_wr_en_after_rst", wr_en, 0);
        repeat (4) step();
        chk("t6_count", got.size(), 1);
        chk("t6_tag", got[0], 8'hA2);
        chk("t6_drop", drop_count, 0);

        // drop counter saturation
        do_reset();
        fifo_full = 1'b1;
        for (int n = 0; n < 6; n++) strobe(3'b111, 16'h1, 16'h2, 16'h3);
        chk("sat_drop", drop_count, SAT);
        fifo_full = 1'b0;

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            enable    = ($urandom_range(0, 9) != 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            ch_valid  = NCH'($urandom) & NCH'($urandom);
            ch_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            step();
        end
        rst_n = 1'b1;
        ch_valid = '0;
        fifo_full = 1'b0;
        repeat (20) step();
        chk("rand_drained", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
